// File: rtl/ef_apb_requester.sv
// APB3 requester: accepts one register command at a time and returns read data/status on a valid/ready port.
// Define EF_APB_REQ_TIMEOUT_EN to abort transfers whose PREADY stays low for TIMEOUT_CYCLES ACCESS cycles.
module ef_apb_requester #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
`ifdef EF_APB_REQ_TIMEOUT_EN
    output logic          timeout_flag,
`endif
    output logic [AW-1:0] PADDR,
    output logic          PWRITE,
    output logic          PSEL,
    output logic          PENABLE,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          cmd_ready_q;
    logic          psel_q;
    logic          penable_q;
    logic          rsp_valid_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q;
    logic          pwrite_q;
    logic [DW-1:0] rdata_q;
    logic          accept;
    logic          complete;
    logic          abort;

    // cmd_ready_q is only ever high while idle, so it alone qualifies acceptance.
    assign accept   = cmd_valid && cmd_ready_q;
    assign complete = (state_q == ST_ACCESS) && PREADY;

`ifdef EF_APB_REQ_TIMEOUT_EN
    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q;
    logic          flag_q;

    // The limit is hit on the PREADY-low cycle that brings the count to TIMEOUT_CYCLES; PREADY high wins.
    assign abort = (state_q == ST_ACCESS) && !PREADY && (wait_cnt_q == LAST_WAIT);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_SETUP) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_ACCESS) && !PREADY) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            flag_q     <= abort;
            if (complete) begin
                err_q <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_err      = err_q;
    assign timeout_flag = flag_q;
`else
    assign abort   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (complete || abort) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus and handshake outputs are registered copies of the next state so they never glitch.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q   <= (state_d == ST_ACCESS);
            rsp_valid_q <= (state_d == ST_RESP);
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwdata_q <= cmd_wdata;
                pwrite_q <= cmd_write;
            end
            if (complete) begin
                rdata_q <= pwrite_q ? '0 : PRDATA;
            end else if (abort) begin
                rdata_q <= '0;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;

endmodule

// File: tb/tb_ef_apb_requester.sv
// Self-checking bench for ef_apb_requester: randomized APB completer plus a word-memory reference model.
// Runs the timeout scenario when EF_APB_REQ_TIMEOUT_EN is defined, otherwise checks that ACCESS waits indefinitely.
module tb_ef_apb_requester;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef EF_APB_REQ_TIMEOUT_EN
    logic        timeout_flag;
`endif
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = 32'h0;
    logic        PREADY = 1'b0;

    int checks = 0;
    int errors = 0;

    // Completer state and the independent reference memory the expectations come from.
    logic [31:0] mem[16];
    logic [31:0] ref_mem[16];
    int          wait_states = 0;
    bit          stuck = 1'b0;
    int          low_left = 0;
    bit          in_access = 1'b0;

    ef_apb_requester #(
        .AW(32),
        .DW(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
`ifdef EF_APB_REQ_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .PADDR(PADDR),
        .PWRITE(PWRITE),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // APB completer: wait_states low cycles per ACCESS (or forever when stuck), junk outside ACCESS.
    always @(posedge PCLK) begin
        #1;
        if (PSEL && PENABLE) begin
            if (!in_access) begin
                in_access = 1'b1;
                low_left  = wait_states;
            end
            if (stuck || low_left > 0) begin
                PREADY = 1'b0;
                PRDATA = $urandom;
                if (low_left > 0) low_left--;
            end else begin
                PREADY = 1'b1;
                PRDATA = PWRITE ? $urandom : mem[PADDR[5:2]];
            end
        end else begin
            in_access = 1'b0;
            PREADY    = 1'($urandom_range(0, 1));
            PRDATA    = $urandom;
        end
    end

    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] = PWDATA;
    end

    task automatic issue_cmd(input bit w, input logic [31:0] addr, input logic [31:0] data, output bit ok);
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = addr;
        cmd_wdata = data;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge PCLK);
            ok = cmd_ready;
            @(posedge PCLK);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input bit w, input logic [31:0] addr, input logic [31:0] data,
                           input int waits, input int hold);
        logic [31:0] exp_rd;
        logic [2:0]  exp_ph;
        bit          ok;
        @(posedge PCLK);
        #1;
        wait_states = waits;
        stuck       = 1'b0;
        rsp_ready   = (hold == 0);
        exp_rd      = w ? 32'h0 : ref_mem[addr[5:2]];
        if (w) ref_mem[addr[5:2]] = data;
        issue_cmd(w, addr, data, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL txn_accept: cmd_ready=0 for 20 cycles, required 1");
            return;
        end
        for (int k = 1; k <= waits + 3; k++) begin
            @(negedge PCLK);
            exp_ph = {k <= waits + 2, (k >= 2) && (k <= waits + 2), k == waits + 3};
            checks++;
            if ({PSEL, PENABLE, rsp_valid} !== exp_ph) begin
                errors++;
                $display("FAIL txn_phase k=%0d: psel/penable/rsp_valid=%b required %b", k, {PSEL, PENABLE, rsp_valid}, exp_ph);
            end
            checks++;
            if ({PADDR, PWDATA, PWRITE} !== {addr, data, w}) begin
                errors++;
                $display("FAIL txn_bus k=%0d: paddr=%h pwdata=%h pwrite=%b required %h %h %b", k, PADDR, PWDATA, PWRITE, addr, data, w);
            end
`ifdef EF_APB_REQ_TIMEOUT_EN
            checks++;
            if (timeout_flag !== 1'b0) begin
                errors++;
                $display("FAIL txn_tflag k=%0d: timeout_flag=%b required 0", k, timeout_flag);
            end
`endif
        end
        checks++;
        if (rsp_rdata !== exp_rd || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL txn_rsp: rdata=%h err=%b required %h 0", rsp_rdata, rsp_err, exp_rd);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge PCLK);
            checks++;
            if ({rsp_valid, cmd_ready, PSEL, rsp_err} !== 4'b1000 || rsp_rdata !== exp_rd) begin
                errors++;
                $display("FAIL txn_hold h=%0d: valid/ready/psel/err=%b rdata=%h required 1000 %h", h, {rsp_valid, cmd_ready, PSEL, rsp_err}, rsp_rdata, exp_rd);
            end
        end
        if (hold > 0) begin
            @(posedge PCLK);
            #1;
            rsp_ready = 1'b1;
            @(negedge PCLK);
        end
        @(negedge PCLK);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL txn_idle: rsp_valid/cmd_ready=%b required 01", {rsp_valid, cmd_ready});
        end
        $display("txn %s addr=%h wdata=%h waits=%0d hold=%0d exp_rdata=%h", w ? "WR" : "RD", addr, data, waits, hold, exp_rd);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge PCLK);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/err/psel/penable/pwrite=%b required 000000", {cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE});
        end
        checks++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h required 0", PADDR, PWDATA, rsp_rdata);
        end
`ifdef EF_APB_REQ_TIMEOUT_EN
        checks++;
        if (timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_tflag: timeout_flag=%b required 0", timeout_flag);
        end
`endif
        #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({cmd_ready, PSEL} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: cmd_ready/psel=%b required 10", {cmd_ready, PSEL});
        end
        $display("txn reset released");
    endtask

    task automatic test_write_single();
        run_txn(1'b1, 32'h0000_0008, 32'hA5A5_0001, 0, 0);
    endtask

    task automatic test_read_wait();
        mem[4]     = 32'h1234_5678;
        ref_mem[4] = 32'h1234_5678;
        run_txn(1'b0, 32'h0000_0010, $urandom, 3, 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] a_addr, b_addr, exp_a, exp_b;
        bit ok, got;
        a_addr = $urandom; a_addr[1:0] = 2'b00;
        b_addr = $urandom; b_addr[1:0] = 2'b00;
        exp_a  = ref_mem[a_addr[5:2]];
        exp_b  = ref_mem[b_addr[5:2]];
        @(posedge PCLK);
        #1;
        wait_states = 0;
        stuck       = 1'b0;
        rsp_ready   = 1'b0;
        issue_cmd(1'b0, a_addr, 32'h0, ok);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = b_addr;
        cmd_wdata = $urandom;
        repeat (3) @(negedge PCLK);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== exp_a) begin
            errors++;
            $display("FAIL bp_first: accepted=%b rsp_valid=%b rdata=%h required 1 1 %h", ok, rsp_valid, rsp_rdata, exp_a);
        end
        for (int h = 0; h < 5; h++) begin
            @(negedge PCLK);
            checks++;
            if ({rsp_valid, cmd_ready, PSEL, rsp_err} !== 4'b1000 || rsp_rdata !== exp_a) begin
                errors++;
                $display("FAIL bp_hold h=%0d: valid/ready/psel/err=%b rdata=%h required 1000 %h", h, {rsp_valid, cmd_ready, PSEL, rsp_err}, rsp_rdata, exp_a);
            end
        end
        @(posedge PCLK);
        #1;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({cmd_ready, PSEL, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL bp_after_hs: ready/psel/valid=%b required 100", {cmd_ready, PSEL, rsp_valid});
        end
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b10 || PADDR !== b_addr) begin
            errors++;
            $display("FAIL bp_second_setup: psel/penable=%b paddr=%h required 10 %h", {PSEL, PENABLE}, PADDR, b_addr);
        end
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge PCLK);
            got = rsp_valid;
        end
        checks++;
        if (!got || rsp_rdata !== exp_b) begin
            errors++;
            $display("FAIL bp_second_rsp: seen=%b rdata=%h required 1 %h", got, rsp_rdata, exp_b);
        end
        $display("txn backpressure a=%h b=%h", a_addr, b_addr);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[4];
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int          acc[$];
        bit          psel_hist[24];
        int          sent, rsps, bad;
        for (int i = 0; i < 4; i++) begin
            addrs[i] = $urandom;
            addrs[i][1:0] = 2'b00;
        end
        @(posedge PCLK);
        #1;
        wait_states = 0;
        stuck       = 1'b0;
        rsp_ready   = 1'b1;
        sent        = 0;
        rsps        = 0;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_addr    = addrs[0];
        cmd_wdata   = $urandom;
        for (int c = 0; c < 24; c++) begin
            @(negedge PCLK);
            psel_hist[c] = PSEL;
            if (rsp_valid) begin
                rsps++;
                e = 32'hDEAD_BEEF;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                if (rsp_rdata !== e) begin
                    errors++;
                    $display("FAIL b2b_rdata c=%0d: rdata=%h required %h", c, rsp_rdata, e);
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc.push_back(c);
                exp_q.push_back(ref_mem[addrs[sent][5:2]]);
                sent++;
            end
            @(posedge PCLK);
            #1;
            if (sent >= 4) cmd_valid = 1'b0;
            else cmd_addr = addrs[sent];
        end
        checks++;
        if (acc.size() != 4 || rsps != 4) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d responses=%0d required 4 4", acc.size(), rsps);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc[i] - acc[i-1] != 4) begin
                    errors++;
                    $display("FAIL b2b_spacing i=%0d: %0d cycles required 4", i, acc[i] - acc[i-1]);
                end
            end
            bad = 0;
            for (int c = acc[0] + 1; c <= acc[0] + 16 && c < 24; c++) begin
                if (psel_hist[c] !== (((c - acc[0]) % 4 == 1) || ((c - acc[0]) % 4 == 2))) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_psel_pattern: %0d cycles wrong required 0", bad);
            end
        end
        $display("txn back_to_back accepts=%0d responses=%0d", acc.size(), rsps);
    endtask

`ifdef EF_APB_REQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] addr;
        logic [2:0]  exp_ph;
        bit          ok;
        addr = $urandom; addr[1:0] = 2'b00;
        @(posedge PCLK);
        #1;
        stuck       = 1'b1;
        wait_states = 0;
        rsp_ready   = 1'b0;
        issue_cmd(1'b0, addr, 32'h0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_accept: cmd_ready never 1");
        end
        for (int k = 1; k <= 11; k++) begin
            @(negedge PCLK);
            exp_ph = {k <= 9, (k >= 2) && (k <= 9), k >= 10};
            checks++;
            if ({PSEL, PENABLE, rsp_valid} !== exp_ph || timeout_flag !== (k == 10)) begin
                errors++;
                $display("FAIL to_phase k=%0d: psel/penable/valid=%b tflag=%b required %b %b", k, {PSEL, PENABLE, rsp_valid}, timeout_flag, exp_ph, k == 10);
            end
            if (k >= 10) begin
                checks++;
                if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL to_rsp k=%0d: err=%b rdata=%h required 1 0", k, rsp_err, rsp_rdata);
                end
            end
        end
        @(posedge PCLK);
        #1;
        stuck     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL to_idle: rsp_valid/cmd_ready=%b required 01", {rsp_valid, cmd_ready});
        end
        $display("txn timeout abort addr=%h", addr);
        run_txn(1'b0, addr, $urandom, 7, 0);
    endtask
`else
    task automatic test_no_timeout();
        logic [31:0] addr, exp_rd;
        bit          ok, got;
        addr   = $urandom; addr[1:0] = 2'b00;
        exp_rd = ref_mem[addr[5:2]];
        @(posedge PCLK);
        #1;
        stuck     = 1'b1;
        rsp_ready = 1'b1;
        issue_cmd(1'b0, addr, 32'h0, ok);
        for (int k = 1; k <= 40; k++) begin
            @(negedge PCLK);
            if (k >= 2) begin
                checks++;
                if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
                    errors++;
                    $display("FAIL nto_wait k=%0d: psel/penable/valid=%b required 110", k, {PSEL, PENABLE, rsp_valid});
                end
            end
        end
        @(posedge PCLK);
        #1;
        stuck = 1'b0;
        got   = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge PCLK);
            got = rsp_valid;
        end
        checks++;
        if (!ok || !got || rsp_rdata !== exp_rd || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL nto_rsp: accepted=%b seen=%b rdata=%h err=%b required 1 1 %h 0", ok, got, rsp_rdata, rsp_err, exp_rd);
        end
        $display("txn long wait addr=%h rdata=%h", addr, rsp_rdata);
    endtask
`endif

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 24; i++) begin
            addr = $urandom;
            addr[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] addr;
        bit          ok;
        int          bad;
        addr = $urandom; addr[1:0] = 2'b00;
        @(posedge PCLK);
        #1;
        stuck     = 1'b1;
        rsp_ready = 1'b1;
        issue_cmd(1'b0, addr, 32'h0, ok);
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if (!ok || {PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre: accepted=%b psel/penable=%b required 1 11", ok, {PSEL, PENABLE});
        end
        #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_async: psel/penable/valid/ready=%b required 0000", {PSEL, PENABLE, rsp_valid, cmd_ready});
        end
        @(negedge PCLK);
        #1;
        stuck   = 1'b0;
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_release: cmd_ready/rsp_valid=%b required 10", {cmd_ready, rsp_valid});
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid_stale: %0d cycles with rsp_valid or PSEL high, required 0", bad);
        end
        $display("txn reset mid-access addr=%h", addr);
        run_txn(1'b0, addr, $urandom, 1, 0);
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write_single();
        test_read_wait();
        test_backpressure();
        test_back_to_back();
`ifdef EF_APB_REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 ns, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
